// File: rtl/vec_pkg.sv
// Shared constants, sequencer state type and lane helper for the vector memory unit.
package vec_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned ELEM_W = 16;
    localparam int unsigned VEC_W  = LANES * ELEM_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } vmu_state_t;

    // Low bit of lane k within a packed vector.
    function automatic int unsigned lane_lo(input logic [1:0] k);
        return 32'(k) * ELEM_W;
    endfunction

endpackage

// File: rtl/vmu_seq.sv
// Sequencer for the vector memory unit: FSM, lane counter and the
// one-cycle-delayed capture strobe that tracks memory read latency.
module vmu_seq
    import vec_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       is_store,
    output logic       accept,
    output logic       busy,
    output logic       load_act,
    output logic       store_act,
    output logic       drain,
    output logic       done,
    output logic [1:0] lane,
    output logic       cap_act,
    output logic [1:0] cap_lane
);

    vmu_state_t state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       cap_q;
    logic [1:0] cap_lane_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = is_store ? STORE : LOAD;
            LOAD:    if (cnt_q == 2'd3) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            STORE:   if (cnt_q == 2'd3) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = 2'd0;
        if (load_act || store_act) begin
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            cap_q      <= 1'b0;
            cap_lane_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            // Read data returns one cycle after the strobe, so capture trails the issue.
            cap_q      <= load_act;
            cap_lane_q <= cnt_q;
        end
    end

    assign accept    = (state_q == IDLE) && start;
    assign busy      = (state_q != IDLE);
    assign load_act  = (state_q == LOAD);
    assign store_act = (state_q == STORE);
    assign drain     = (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign lane      = cnt_q;
    assign cap_act   = cap_q;
    assign cap_lane  = cap_lane_q;

endmodule

// File: rtl/vector_mem_unit.sv
// Vector load/store engine: moves a 4 x 16-bit vector between the lane array and
// a single-port 16-bit memory, one word per cycle.
module vector_mem_unit
    import vec_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LANES-1:0]  lane_mask,
    input  logic [VEC_W-1:0]  st_vec,
    output logic [VEC_W-1:0]  ld_vec,
    output logic              rd_we,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ELEM_W-1:0] mem_wdata,
    input  logic [ELEM_W-1:0] mem_rdata
);

    logic       accept;
    logic       load_act;
    logic       store_act;
    logic       drain;
    logic [1:0] lane;
    logic       cap_act;
    logic [1:0] cap_lane;

    logic [ADDR_W-1:0] base_q;
    logic [LANES-1:0]  mask_q;
    logic [VEC_W-1:0]  st_vec_q;
    logic              is_store_q;
    logic [VEC_W-1:0]  asm_q, asm_d;
    logic [VEC_W-1:0]  ld_vec_q;

    vmu_seq u_seq (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_store  (is_store),
        .accept    (accept),
        .busy      (busy),
        .load_act  (load_act),
        .store_act (store_act),
        .drain     (drain),
        .done      (done),
        .lane      (lane),
        .cap_act   (cap_act),
        .cap_lane  (cap_lane)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q     <= '0;
            mask_q     <= '0;
            st_vec_q   <= '0;
            is_store_q <= 1'b0;
        end else if (accept) begin
            base_q     <= base_addr;
            mask_q     <= lane_mask;
            st_vec_q   <= st_vec;
            is_store_q <= is_store;
        end
    end

    // Masked lanes assemble as zero regardless of what the memory returns.
    always_comb begin
        asm_d = asm_q;
        if (cap_act) begin
            asm_d[lane_lo(cap_lane) +: ELEM_W] = mask_q[cap_lane] ? mem_rdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q    <= '0;
            ld_vec_q <= '0;
        end else begin
            asm_q <= asm_d;
            if (drain) begin
                ld_vec_q <= asm_d;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (load_act || store_act) begin
            mem_addr = base_q + ADDR_W'(lane);
        end
        if (load_act) begin
            mem_re = mask_q[lane];
        end
        if (store_act) begin
            mem_we    = mask_q[lane];
            mem_wdata = st_vec_q[lane_lo(lane) +: ELEM_W];
        end
    end

    assign ld_vec = ld_vec_q;
    assign rd_we  = done && !is_store_q;

endmodule

// File: tb/tb_vector_mem_unit.sv
// Self-checking bench for vector_mem_unit: directed table, reset/corner sequences
// and randomized operations against a behavioural memory and vector model.
module tb_vector_mem_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [15:0] base_addr;
    logic [3:0]  lane_mask;
    logic [63:0] st_vec;
    logic [63:0] ld_vec;
    logic        rd_we;
    logic        busy;
    logic        done;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic        pre_en = 1'b0;
    logic [15:0] pre_addr = 16'h0;
    logic [15:0] pre_data = 16'h0;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [63:0] ld_prev = 64'h0;

    logic [15:0] mem [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];

    always #5 clk = ~clk;

    vector_mem_unit #(.ADDR_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_store  (is_store),
        .base_addr (base_addr),
        .lane_mask (lane_mask),
        .st_vec    (st_vec),
        .ld_vec    (ld_vec),
        .rd_we     (rd_we),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Unwritten words read back as a fixed address hash.
    function automatic logic [15:0] pat(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    // Memory with one-cycle read latency; rdata is garbage when not reading.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : pat(mem_addr);
        else        mem_rdata <= 16'($urandom);
        if (pre_en)      mem[pre_addr] = pre_data;
        else if (mem_we) mem[mem_addr] = mem_wdata;
    end

    task automatic chk(input string name, input int c, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
    endtask

    // c = 0 is the start/idle cycle, 1..4 the lane cycles, lat the done cycle.
    task automatic check_cycle(input string tag, input int c, input logic st,
                               input logic [15:0] base, input logic [3:0] mask,
                               input logic [63:0] sv, input int lat, input logic [63:0] exp_ld);
        logic        act;
        logic        en;
        logic [1:0]  k;
        logic [15:0] e_addr, a_addr, e_wd, a_wd;
        logic [63:0] e_ld;
        act    = (c >= 1) && (c <= 4);
        k      = 2'(c - 1);
        en     = act && mask[k];
        e_addr = en ? 16'(base + 16'(k)) : 16'h0;
        a_addr = en ? mem_addr : 16'h0;
        e_wd   = (st && en) ? sv[16*k +: 16] : 16'h0;
        a_wd   = (st && act && !mask[k]) ? 16'h0 : mem_wdata;
        e_ld   = (c == lat) ? exp_ld : ld_prev;
        chk({tag, " ctl"}, c, 64'({mem_re, mem_we, a_addr, a_wd, busy, done, rd_we}),
            64'({!st && en, st && en, e_addr, e_wd, c >= 1, c == lat, !st && (c == lat)}));
        chk({tag, " ld_vec"}, c, ld_vec, e_ld);
    endtask

    task automatic drive_idle();
        start     = 1'b0;
        pre_en    = 1'b0;
        is_store  = 1'($urandom);
        base_addr = 16'($urandom);
        lane_mask = 4'($urandom);
        st_vec    = {$urandom, $urandom};
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        drive_idle();
        #1 check_cycle(tag, 0, 1'b0, 16'h0, 4'h0, 64'h0, 99, ld_prev);
    endtask

    task automatic preset(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        drive_idle();
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        #1 check_cycle("preset", 0, 1'b0, 16'h0, 4'h0, 64'h0, 99, ld_prev);
        ref_mem[a] = d;
    endtask

    task automatic run_op(input string tag, input logic st, input logic [15:0] base,
                          input logic [3:0] mask, input logic [63:0] sv, input int extra_c,
                          input logic [63:0] exp_ld);
        int lat;
        lat = st ? 5 : 6;
        @(negedge clk);
        pre_en    = 1'b0;
        start     = 1'b1;
        is_store  = st;
        base_addr = base;
        lane_mask = mask;
        st_vec    = sv;
        #1 check_cycle(tag, 0, st, base, mask, sv, lat, exp_ld);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            drive_idle();
            start = (c == extra_c);
            #1 check_cycle(tag, c, st, base, mask, sv, lat, exp_ld);
        end
        if (st) begin
            for (int k = 0; k < 4; k++) begin
                if (mask[k]) ref_mem[16'(base + 16'(k))] = sv[16*k +: 16];
            end
        end
        ld_prev = exp_ld;
    endtask

    typedef struct {
        logic        st;
        logic [15:0] base;
        logic [3:0]  mask;
        logic [63:0] sv;
        logic        has_pre;
        logic [63:0] pre;
        int          extra;
        logic [63:0] exp_ld;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic        st;
        logic [15:0] base;
        logic [3:0]  mask;
        logic [63:0] sv;
        logic [63:0] e;

        tbl[0] = '{1'b0, 16'h0010, 4'hF, 64'h0, 1'b1, 64'h4444_3333_2222_1111, -1,
                   64'h4444_3333_2222_1111};
        tbl[1] = '{1'b1, 16'h0100, 4'hF, 64'hDEAD_BEEF_CAFE_0001, 1'b0, 64'h0, -1,
                   64'h4444_3333_2222_1111};
        tbl[2] = '{1'b0, 16'h0020, 4'b0101, 64'h0, 1'b1, 64'hDDDD_CCCC_BBBB_AAAA, -1,
                   64'h0000_CCCC_0000_AAAA};
        tbl[3] = '{1'b1, 16'hFFFE, 4'hF, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'h0, 2,
                   64'h0000_CCCC_0000_AAAA};
        tbl[4] = '{1'b0, 16'h0100, 4'hF, 64'h0, 1'b0, 64'h0, -1, 64'hDEAD_BEEF_CAFE_0001};
        tbl[5] = '{1'b0, 16'hFFFE, 4'hF, 64'h0, 1'b0, 64'h0, -1, 64'h1234_5678_9ABC_DEF0};

        rst = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        drive_idle();
        #1 check_cycle("reset", 0, 1'b0, 16'h0, 4'h0, 64'h0, 99, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table; entries without a preset follow the previous one back-to-back.
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].has_pre) begin
                for (int k = 0; k < 4; k++) begin
                    preset(16'(tbl[i].base + 16'(k)), tbl[i].pre[16*k +: 16]);
                end
            end
            run_op($sformatf("tbl%0d", i), tbl[i].st, tbl[i].base, tbl[i].mask, tbl[i].sv,
                   tbl[i].extra, tbl[i].exp_ld);
            if (i == 3) idle_cycle("after_dup_start");
        end

        // Reset in the middle of a load abandons it and clears ld_vec.
        for (int k = 0; k < 4; k++) preset(16'h0200 + 16'(k), 16'h7000 + 16'(k));
        @(negedge clk);
        pre_en    = 1'b0;
        start     = 1'b1;
        is_store  = 1'b0;
        base_addr = 16'h0200;
        lane_mask = 4'hF;
        st_vec    = 64'h0;
        #1 check_cycle("rst_op", 0, 1'b0, 16'h0200, 4'hF, 64'h0, 6, ld_prev);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            drive_idle();
            if (c == 3) rst = 1'b1;
            #1 check_cycle("rst_op", c, 1'b0, 16'h0200, 4'hF, 64'h0, 6, ld_prev);
        end
        ld_prev = 64'h0;
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        #1 check_cycle("post_rst", 0, 1'b0, 16'h0, 4'h0, 64'h0, 99, ld_prev);
        for (int i = 0; i < 3; i++) idle_cycle("post_rst_idle");
        run_op("after_rst", 1'b0, 16'h0200, 4'hF, 64'h0, -1, 64'h7003_7002_7001_7000);

        // Randomized operations against the reference memory.
        for (int i = 0; i < 40; i++) begin
            st   = 1'($urandom);
            mask = 4'($urandom);
            sv   = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0:       base = 16'($urandom_range(16'hFFFC, 16'hFFFF));
                1:       base = 16'h0300 + 16'($urandom_range(0, 7));
                default: base = 16'($urandom);
            endcase
            if (st) begin
                e = ld_prev;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    e[16*k +: 16] = mask[k] ? ref_rd(16'(base + 16'(k))) : 16'h0;
                end
            end
            repeat ($urandom_range(0, 2)) idle_cycle("rnd_idle");
            run_op($sformatf("rnd%0d", i), st, base, mask, sv, -1, e);
        end
        idle_cycle("final_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vector_mem_unit.md
Name: vector_mem_unit

Overview:
- Memory side of the 4-lane 16-bit SIMD datapath.
- Load direction: reads four consecutive 16-bit memory words and packs them into a 64-bit vector register value. Word k goes into lane k, bits [16k+15:16k].
- Store direction: latches a 64-bit lane result and writes its four 16-bit lanes to four consecutive addresses.
- Sits between the vector register file / lane array and a single-port 16-bit data memory with 1-cycle synchronous read latency.

Parameters:
- ADDR_W, 16, memory word-address width.
- ELEM_W, 16, lane element width; fixed to match the memory word.
- LANES, 4, lanes per vector. Vector width is LANES*ELEM_W = 64.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load; sampled with start.
- base_addr  in  ADDR_W  address of lane 0; sampled with start.
- lane_mask  in  LANES  per-lane enable; sampled with start.
- st_vec  in  64  vector to store (lane results); sampled with start.
- ld_vec  out  64  assembled load vector, lane k at [16k+15:16k].
- rd_we  out  1  1-cycle register-file write strobe for a completed load.
- busy  out  1  high whenever state != IDLE.
- done  out  1  1-cycle completion pulse, for both load and store.
- mem_addr  out  ADDR_W  memory address.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  ELEM_W  memory write data.
- mem_rdata  in  ELEM_W  read data; valid the cycle after mem_re.

Behaviour:
- Reset values: all outputs 0; state IDLE; lane counter 0; latched registers 0.
- Reset mid-operation: abandon the operation. Strobes are low from the next edge. No done, no rd_we. ld_vec is cleared to 0.
- States: IDLE, LOAD, DRAIN, STORE, DONE.
- IDLE, start=1 at cycle T: latch base_addr, lane_mask, st_vec and is_store. Next state is LOAD or STORE.
- IDLE, start=0: stay in IDLE.
- start while busy: ignored; no queuing.
- LOAD, cycles T+1..T+4, k = 0..3:
  - mem_addr = base+k; mem_re = lane_mask[k].
  - When k = 3, go to DRAIN.
- Capture: in cycles T+2..T+5, word k is written into the internal assembly register.
  - A lane with mask 0 gets 0, and mem_rdata is ignored for it.
  - DRAIN (T+5) captures word 3, then goes to DONE.
- STORE, cycles T+1..T+4:
  - mem_addr = base+k; mem_wdata = latched st_vec lane k; mem_we = lane_mask[k].
  - Masked lanes still consume their cycle, so latency is fixed.
  - After k = 3, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
  - After a load: rd_we=1 in the same cycle, and ld_vec updates to the assembled value at the DONE edge.
- ld_vec behaviour: holds its value until the next load completes or reset. Stores never change ld_vec.
- Latency, start cycle T to done cycle: load T+6, store T+5.
  - A new start is accepted in the first cycle after DONE (back-to-back).
- Address arithmetic: base+k is computed modulo 2^ADDR_W (wraps from 0xFFFF to 0x0000).
- Outside the active cycles: mem_re and mem_we are 0 and mem_wdata is 0.
- mem_re and mem_we are never high in the same cycle.

Decomposition:
- Package vec_pkg:
  - LANES, ELEM_W and VEC_W constants.
  - vmu_state_t enum {IDLE, LOAD, DRAIN, STORE, DONE}.
  - lane-slice helper function (lane k -> bit range).
- One natural sub-module, vmu_seq: the FSM plus the 2-bit lane counter, producing the active lane index, phase strobes and done.
- The top level contains only datapath latches, lane mux/demux and address add.

Test Plan:
- Load, mask 4'hF, base 0x0010, memory [0x10..0x13] = 1111,2222,3333,4444 -> done at T+6 with rd_we=1; ld_vec = 0x4444_3333_2222_1111.
- Store, mask 4'hF, base 0x0100, st_vec = 0xDEAD_BEEF_CAFE_0001 -> writes 0x0001, 0xCAFE, 0xBEEF, 0xDEAD to 0x100..0x103 on T+1..T+4; done at T+5; rd_we stays 0; ld_vec unchanged.
- Load, mask 4'b0101, base 0x0020, memory = AAAA,BBBB,CCCC,DDDD -> mem_re high only at T+1 and T+3; ld_vec = 0x0000_CCCC_0000_AAAA.
- Store, base 0xFFFE, mask 4'hF -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; a second start held high at T+2 is ignored; done pulses exactly once.
- rst asserted at T+3 of a load -> from the next edge busy=0 and mem_re=0; no done/rd_we; ld_vec = 0; a following load completes normally.
- Back-to-back: a store starts in the cycle after a load's DONE -> accepted; no idle gap required.
